// File: rtl/sram_interface.sv
// sram_interface: sequences one latched read or write command onto two
// asynchronous 256Kx16 SRAM chips sharing address and data buses.
// The access runs SETUP -> STROBE -> HOLD, and every SRAM-side pin is registered.
module sram_interface #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET,
  input  logic [1:0]  CMD_IN,
  input  logic [15:0] DATA_IN,
  input  logic [17:0] ADDRESS_IN,
  input  logic        CHIP_SELECT_IN,
  output logic        SRAM_STATUS,
  output logic [15:0] DATA_READ,
  output logic        READ_VALID,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DATA,
  output logic        SRAM_CE1_N,
  output logic        SRAM_CE2_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

  localparam logic [3:0] LP_SETUP  = 4'(SETUP_CYCLES);
  localparam logic [3:0] LP_STROBE = 4'(STROBE_CYCLES);
  localparam logic [3:0] LP_HOLD   = 4'(HOLD_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_armed;
  logic        r_is_rd, r_cs;
  logic [17:0] r_addr;
  logic [15:0] r_wdata;

  logic        w_accept, w_capture;
  logic        w_is_rd_nxt, w_cs_nxt;
  logic [17:0] w_addr_nxt;
  logic [15:0] w_wdata_nxt;

  logic        w_busy, w_ce1_n, w_ce2_n, w_we_n, w_oe_n, w_be_n, w_drive;
  logic [17:0] w_addr_o;

  logic        r_status, r_ce1_n, r_ce2_n, r_we_n, r_oe_n, r_be_n, r_drive;
  logic        r_read_valid;
  logic [17:0] r_addr_o;
  logic [15:0] r_dq_o, r_data_read;

  // A command needs a fresh CMD_IN==0 since the last accept (armed) to start.
  assign w_accept = (r_state == ST_IDLE) && r_armed &&
                    ((CMD_IN == 2'd1) || (CMD_IN == 2'd2));

  // Values the access will use from the next cycle on.
  assign w_is_rd_nxt = w_accept ? (CMD_IN == 2'd2) : r_is_rd;
  assign w_cs_nxt    = w_accept ? CHIP_SELECT_IN  : r_cs;
  assign w_addr_nxt  = w_accept ? ADDRESS_IN      : r_addr;
  assign w_wdata_nxt = w_accept ? DATA_IN         : r_wdata;

  // Read data is sampled on the last STROBE edge, while OE_N is still low.
  assign w_capture = (r_state == ST_STROBE) && (r_cnt == 4'd1) && r_is_rd;

  // Command latch: loads only on accept, so input changes while busy are ignored.
  always_ff @(posedge CLK_48MHZ) begin
    r_is_rd <= w_is_rd_nxt;
    r_cs    <= w_cs_nxt;
    r_addr  <= w_addr_nxt;
    r_wdata <= w_wdata_nxt;
  end

  // State register, phase down-counter and armed flag.
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (CMD_IN == 2'd0)
        r_armed <= 1'b1;
      else if (w_accept)
        r_armed <= 1'b0;
    end
  end

  // Next-state logic: each phase loads its length and advances when the count reaches 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = LP_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = LP_STROBE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = LP_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Pin decode from the next state, so the registered pins line up with the phase.
  always_comb begin
    w_busy   = (w_state_nxt != ST_IDLE);
    w_ce1_n  = 1'b1;
    w_ce2_n  = 1'b1;
    w_we_n   = 1'b1;
    w_oe_n   = 1'b1;
    w_drive  = 1'b0;
    w_addr_o = r_addr_o;
    if (w_busy) begin
      w_addr_o = w_addr_nxt;
      w_ce1_n  = w_cs_nxt;
      w_ce2_n  = !w_cs_nxt;
      w_drive  = !w_is_rd_nxt;
      if (w_is_rd_nxt)
        w_oe_n = !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE));
      else
        w_we_n = (w_state_nxt != ST_STROBE);
    end
    w_be_n = w_ce1_n & w_ce2_n;
  end

  // Registered SRAM control pins and busy flag.
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      r_status <= 1'b0;
      r_ce1_n  <= 1'b1;
      r_ce2_n  <= 1'b1;
      r_we_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_be_n   <= 1'b1;
      r_drive  <= 1'b0;
      r_addr_o <= 18'd0;
    end else begin
      r_status <= w_busy;
      r_ce1_n  <= w_ce1_n;
      r_ce2_n  <= w_ce2_n;
      r_we_n   <= w_we_n;
      r_oe_n   <= w_oe_n;
      r_be_n   <= w_be_n;
      r_drive  <= w_drive;
      r_addr_o <= w_addr_o;
    end
  end

  // Write data register; visible on the bus only while r_drive is set.
  always_ff @(posedge CLK_48MHZ) begin
    r_dq_o <= w_wdata_nxt;
  end

  // Read capture and the one-cycle valid strobe that accompanies it.
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      r_read_valid <= 1'b0;
      r_data_read  <= 16'd0;
    end else begin
      r_read_valid <= w_capture;
      if (w_capture)
        r_data_read <= SRAM_DATA;
    end
  end

  assign SRAM_DATA   = r_drive ? r_dq_o : 16'bz;
  assign SRAM_STATUS = r_status;
  assign DATA_READ   = r_data_read;
  assign READ_VALID  = r_read_valid;
  assign SRAM_ADDR   = r_addr_o;
  assign SRAM_CE1_N  = r_ce1_n;
  assign SRAM_CE2_N  = r_ce2_n;
  assign SRAM_WE_N   = r_we_n;
  assign SRAM_OE_N   = r_oe_n;
  assign SRAM_UB_N   = r_be_n;
  assign SRAM_LB_N   = r_be_n;

endmodule
